// File: rtl/config_trit_decoder.sv
// config_trit_decoder: resolves four board-strap trits (two resistor-coupled pin
// pairs) by driving each pin's partner high then low and sampling the pin after a
// settle time. Scans once after reset; software can re-trigger and read results.
module config_trit_decoder #(
    parameter logic [4:0] BASE_ADDR     = 5'h0,
    parameter int         SETTLE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] csr_a,
    input  logic [7:0] csr_di,
    input  logic       csr_we,
    output logic [7:0] csr_do,
    inout  wire  [3:0] trits,
    output logic [7:0] decoded,
    output logic       valid
);

    typedef enum logic [2:0] {
        START,
        IDLE,
        ODD_HI,
        ODD_LO,
        EVEN_HI,
        EVEN_LO,
        DONE
    } state_t;

    localparam logic [4:0] RES_ADDR = BASE_ADDR + 5'd1;
    localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] sh_q, sh_d;
    logic [3:0] sl_q, sl_d;
    logic [7:0] decoded_q, decoded_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;

    logic       start_wr;
    logic       cnt_zero;
    logic [3:0] trits_oe;
    logic [3:0] trits_o;

    // Only bit 0 of the control write carries meaning.
    logic       unused_di;
    assign unused_di = &{1'b0, csr_di[7:1]};

    // Per trit: pin high-sample / low-sample pair -> 2-bit code
    // (0,0) GND=00, (1,1) Vcc=01, (1,0) open=10, (0,1) fault=11.
    function automatic logic [7:0] decode(input logic [3:0] sh, input logic [3:0] sl);
        logic [7:0] d;
        d = 8'h00;
        for (int k = 0; k < 4; k++) begin
            d[2*k+1] = sh[k] ^ sl[k];
            d[2*k]   = sl[k];
        end
        return d;
    endfunction

    assign start_wr = csr_we && (csr_a == BASE_ADDR) && csr_di[0];
    assign cnt_zero = (cnt_q == 8'd0);

    // Next-state logic: scan sequencing, sampling at the end of each phase, result capture.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        sl_d      = sl_q;
        decoded_d = decoded_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        case (state_q)
            START: begin
                state_d = ODD_HI;
                cnt_d   = CNT_LOAD;
                busy_d  = 1'b1;
                valid_d = 1'b0;
            end
            IDLE: begin
                if (start_wr) begin
                    state_d = ODD_HI;
                    cnt_d   = CNT_LOAD;
                    busy_d  = 1'b1;
                    valid_d = 1'b0;
                end
            end
            ODD_HI: begin
                if (cnt_zero) begin
                    sh_d[0] = trits[0];
                    sh_d[2] = trits[2];
                    state_d = ODD_LO;
                    cnt_d   = CNT_LOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ODD_LO: begin
                if (cnt_zero) begin
                    sl_d[0] = trits[0];
                    sl_d[2] = trits[2];
                    state_d = EVEN_HI;
                    cnt_d   = CNT_LOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            EVEN_HI: begin
                if (cnt_zero) begin
                    sh_d[1] = trits[1];
                    sh_d[3] = trits[3];
                    state_d = EVEN_LO;
                    cnt_d   = CNT_LOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            EVEN_LO: begin
                if (cnt_zero) begin
                    sl_d[1] = trits[1];
                    sl_d[3] = trits[3];
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            DONE: begin
                decoded_d = decode(sh_q, sl_q);
                valid_d   = 1'b1;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers; reset releases the pins immediately via state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= START;
            cnt_q     <= 8'd0;
            sh_q      <= 4'd0;
            sl_q      <= 4'd0;
            decoded_q <= 8'h00;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            sl_q      <= sl_d;
            decoded_q <= decoded_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
        end
    end

    // Pin drive per scan phase: the partner of each pin under test is driven.
    always_comb begin
        trits_oe = 4'b0000;
        trits_o  = 4'b0000;
        case (state_q)
            ODD_HI: begin
                trits_oe = 4'b1010;
                trits_o  = 4'b1010;
            end
            ODD_LO: begin
                trits_oe = 4'b1010;
                trits_o  = 4'b0000;
            end
            EVEN_HI: begin
                trits_oe = 4'b0101;
                trits_o  = 4'b0101;
            end
            EVEN_LO: begin
                trits_oe = 4'b0101;
                trits_o  = 4'b0000;
            end
            default: begin
                trits_oe = 4'b0000;
                trits_o  = 4'b0000;
            end
        endcase
    end

    for (genvar g = 0; g < 4; g++) begin : g_pin
        assign trits[g] = trits_oe[g] ? trits_o[g] : 1'bz;
    end

    // CSR read mux: status, result, zero elsewhere.
    always_comb begin
        csr_do = 8'h00;
        if (csr_a == BASE_ADDR) begin
            csr_do = {busy_q, valid_q, 6'b000000};
        end else if (csr_a == RES_ADDR) begin
            csr_do = decoded_q;
        end
    end

    assign decoded = decoded_q;
    assign valid   = valid_q;

endmodule

// File: tb/tb_config_trit_decoder.sv
// Testbench for config_trit_decoder: a board model answers the DUT's pin drive
// according to strap type, and a strap-level reference predicts decoded codes.
module tb_config_trit_decoder;

    localparam int         S    = 16;
    localparam logic [4:0] BASE = 5'h0;
    localparam logic [4:0] RES  = 5'h1;

    localparam logic [1:0] GND = 2'd0;
    localparam logic [1:0] VCC = 2'd1;
    localparam logic [1:0] OPN = 2'd2;
    localparam logic [1:0] FLT = 2'd3;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic [4:0] csr_a  = 5'h0;
    logic [7:0] csr_di = 8'h00;
    logic       csr_we = 1'b0;
    logic [7:0] csr_do;
    wire  [3:0] trits;
    logic [7:0] decoded;
    logic       valid;

    int vectors     = 0;
    int miscompares = 0;

    // strap type of pin k lives in straps[2k+1:2k]
    logic [7:0] straps = 8'h00;
    logic [3:0] tb_en;
    logic [3:0] tb_val;

    config_trit_decoder #(
        .BASE_ADDR    (BASE),
        .SETTLE_CYCLES(S)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .csr_a  (csr_a),
        .csr_di (csr_di),
        .csr_we (csr_we),
        .csr_do (csr_do),
        .trits  (trits),
        .decoded(decoded),
        .valid  (valid)
    );

    always #5 clk = ~clk;

    // Electrical response of a pin to its partner's level.
    function automatic logic pin_resp(input logic [1:0] s, input logic partner);
        case (s)
            GND:     return 1'b0;
            VCC:     return 1'b1;
            OPN:     return partner;
            default: return ~partner;
        endcase
    endfunction

    function automatic logic [1:0] exp_code(input logic [1:0] s);
        logic sh, sl;
        sh = pin_resp(s, 1'b1);
        sl = pin_resp(s, 1'b0);
        case ({sh, sl})
            2'b00:   return 2'b00;
            2'b11:   return 2'b01;
            2'b10:   return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    function automatic logic [7:0] exp_dec(input logic [7:0] st);
        logic [7:0] r;
        r = 8'h00;
        for (int k = 0; k < 4; k++) r[2*k +: 2] = exp_code(st[2*k +: 2]);
        return r;
    endfunction

    function automatic logic [3:0] exp_oe(input int p);
        return (p < 2) ? 4'b1010 : 4'b0101;
    endfunction

    function automatic logic [3:0] exp_o(input int p);
        return (p % 2 == 0) ? exp_oe(p) : 4'b0000;
    endfunction

    // Board: every pin the DUT leaves undriven is held by its strap / coupling.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            tb_en[k]  = !dut.trits_oe[k];
            tb_val[k] = pin_resp(straps[2*k +: 2],
                                 dut.trits_oe[k^1] ? dut.trits_o[k^1] : 1'b0);
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_board
        assign trits[g] = tb_en[g] ? tb_val[g] : 1'bz;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic read_csr(input logic [4:0] a, output logic [7:0] d);
        csr_a = a;
        #1;
        d = csr_do;
    endtask

    task automatic write_csr(input logic [4:0] a, input logic [7:0] d);
        csr_a  = a;
        csr_di = d;
        csr_we = 1'b1;
        @(posedge clk);
        @(negedge clk);
        csr_we = 1'b0;
        csr_di = 8'h00;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        tick();
        tick();
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", valid); end
        vectors++; if (decoded !== 8'h00) begin miscompares++; $display("FAIL reset_decoded: got %h want 00", decoded); end
        vectors++; if (dut.trits_oe !== 4'b0000) begin miscompares++; $display("FAIL reset_release: oe %b want 0000", dut.trits_oe); end
        read_csr(BASE, d);
        vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL reset_status: got %h want 00", d); end
        read_csr(RES, d);
        vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL reset_result: got %h want 00", d); end
    endtask

    task automatic test_reset_scan();
        logic [7:0] d;
        logic [3:0] eoe, eo;
        straps = {OPN, VCC, GND, OPN};
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 4*S+1; c++) begin
            tick();
            if (c <= 4*S) begin
                eoe = exp_oe((c-1)/S);
                eo  = exp_o((c-1)/S);
                vectors++;
                if (dut.trits_oe !== eoe || (dut.trits_o & eoe) !== eo) begin
                    miscompares++;
                    $display("FAIL drive_seq c=%0d: oe %b o %b want oe %b o %b", c, dut.trits_oe, dut.trits_o & dut.trits_oe, eoe, eo);
                end
                vectors++;
                if ((trits & eoe) !== eo) begin
                    miscompares++;
                    $display("FAIL pin_level c=%0d: got %b want %b", c, trits & eoe, eo);
                end
            end else begin
                vectors++; if (dut.trits_oe !== 4'b0000) begin miscompares++; $display("FAIL done_release: oe %b want 0000", dut.trits_oe); end
            end
            vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL early_valid c=%0d: got %b want 0", c, valid); end
        end
        tick();
        vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL scan_valid: got %b want 1", valid); end
        vectors++; if (decoded !== 8'h92) begin miscompares++; $display("FAIL scan_decoded: got %h want 92", decoded); end
        vectors++; if (decoded !== exp_dec(straps)) begin miscompares++; $display("FAIL scan_model: got %h want %h", decoded, exp_dec(straps)); end
        read_csr(RES, d);
        vectors++; if (d !== 8'h92) begin miscompares++; $display("FAIL scan_result_rd: got %h want 92", d); end
        read_csr(BASE, d);
        vectors++; if (d !== 8'h40) begin miscompares++; $display("FAIL scan_status_rd: got %h want 40", d); end
    endtask

    task automatic test_ignored_writes();
        logic [7:0] d;
        write_csr(RES, 8'hFF);
        write_csr(BASE, 8'hFE);
        tick();
        read_csr(BASE, d);
        vectors++; if (d !== 8'h40) begin miscompares++; $display("FAIL ignored_status: got %h want 40", d); end
        vectors++; if (dut.trits_oe !== 4'b0000) begin miscompares++; $display("FAIL ignored_drive: oe %b want 0000", dut.trits_oe); end
        vectors++; if (decoded !== 8'h92) begin miscompares++; $display("FAIL ignored_decoded: got %h want 92", decoded); end
        read_csr(5'h02, d);
        vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL other_addr_02: got %h want 00", d); end
        read_csr(5'h1F, d);
        vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL other_addr_1f: got %h want 00", d); end
    endtask

    task automatic test_retrigger();
        logic [7:0] d;
        straps = {OPN, VCC, GND, VCC};
        write_csr(BASE, 8'h01);
        for (int c = 0; c <= 4*S; c++) begin
            if (c == 0 || c == S || c == 4*S) begin
                read_csr(BASE, d);
                vectors++; if (d !== 8'h80) begin miscompares++; $display("FAIL retrig_busy c=%0d: got %h want 80", c, d); end
                read_csr(RES, d);
                vectors++; if (d !== 8'h92) begin miscompares++; $display("FAIL retrig_hold c=%0d: got %h want 92", c, d); end
            end
            tick();
        end
        vectors++; if (decoded !== 8'h91) begin miscompares++; $display("FAIL retrig_decoded: got %h want 91", decoded); end
        read_csr(BASE, d);
        vectors++; if (d !== 8'h40) begin miscompares++; $display("FAIL retrig_status: got %h want 40", d); end
    endtask

    task automatic test_busy_write();
        logic [7:0] tgt, d;
        tgt = 8'($urandom);
        straps = tgt;
        write_csr(BASE, 8'h01);
        repeat (9) tick();
        write_csr(BASE, 8'h01);
        for (int c = 11; c <= 4*S; c++) tick();
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL busy_wr_early: valid %b want 0", valid); end
        tick();
        vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL busy_wr_done: valid %b want 1", valid); end
        vectors++; if (decoded !== exp_dec(tgt)) begin miscompares++; $display("FAIL busy_wr_decoded: got %h want %h", decoded, exp_dec(tgt)); end
        for (int c = 0; c < 2*S; c++) begin
            tick();
            read_csr(BASE, d);
            vectors++; if (d !== 8'h40 || dut.trits_oe !== 4'b0000) begin miscompares++; $display("FAIL busy_wr_restart c=%0d: status %h oe %b want 40 0000", c, d, dut.trits_oe); end
        end
    endtask

    task automatic test_random_scans();
        logic [7:0] tgt, d;
        for (int it = 0; it < 8; it++) begin
            tgt = (it == 0) ? 8'hFF : 8'($urandom);
            straps = 8'($urandom);
            write_csr(BASE, 8'h01);
            for (int off = 0; off < 4*S; off++) begin
                straps = ((off + 1) % S == 0) ? tgt : 8'($urandom);
                tick();
            end
            straps = 8'($urandom);
            vectors++; if (valid !== 1'b0 || dut.trits_oe !== 4'b0000) begin miscompares++; $display("FAIL rand_done_phase it=%0d: valid %b oe %b want 0 0000", it, valid, dut.trits_oe); end
            tick();
            vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL rand_valid it=%0d: got %b want 1", it, valid); end
            read_csr(RES, d);
            vectors++; if (d !== exp_dec(tgt)) begin miscompares++; $display("FAIL rand_decoded it=%0d straps=%h: got %h want %h", it, tgt, d, exp_dec(tgt)); end
            if (it == 0) begin
                vectors++; if (decoded !== 8'hFF) begin miscompares++; $display("FAIL fault_code: got %h want ff", decoded); end
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] tgt;
        tgt = 8'($urandom);
        straps = tgt;
        write_csr(BASE, 8'h01);
        repeat (2*S + 3) tick();
        vectors++; if (dut.trits_oe !== 4'b0101) begin miscompares++; $display("FAIL mid_pre_drive: oe %b want 0101", dut.trits_oe); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if (dut.trits_oe !== 4'b0000) begin miscompares++; $display("FAIL mid_async_release: oe %b want 0000", dut.trits_oe); end
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL mid_valid: got %b want 0", valid); end
        vectors++; if (decoded !== 8'h00) begin miscompares++; $display("FAIL mid_decoded: got %h want 00", decoded); end
        tick();
        rst_n = 1'b1;
        for (int c = 1; c <= 4*S+1; c++) tick();
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL mid_rescan_early: valid %b want 0", valid); end
        tick();
        vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL mid_rescan_valid: got %b want 1", valid); end
        vectors++; if (decoded !== exp_dec(tgt)) begin miscompares++; $display("FAIL mid_rescan_decoded: got %h want %h", decoded, exp_dec(tgt)); end
    endtask

    initial begin
        test_reset();
        test_reset_scan();
        test_ignored_writes();
        test_retrigger();
        test_busy_write();
        test_random_scans();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
